thread_mask_decoder: RTL and testbench

THREAD_MASK_DECODER -- requirements
Module: thread_mask_decoder

---
 rtl/thread_mask_decoder.sv | 92 +++++++++
 tb/tb_thread_mask_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/thread_mask_decoder.sv
// Collects binary thread IDs into a lane mask and presents the finished mask
// with a valid/ready handshake. It also keeps a running population count.
//
// state | meaning
// ACCUM | accepting IDs; mask/mask_count show the partial group
// HOLD  | finished mask presented; waiting for mask_ready
module thread_mask_decoder #(
  parameter int MASK_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(MASK_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [ID_WIDTH-1:0]   id,
  input  logic                  id_last,
  output logic                  mask_valid,
  input  logic                  mask_ready,
  output logic [MASK_WIDTH-1:0] mask,
  output logic [ID_WIDTH:0]     mask_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                state_q;
  logic [MASK_WIDTH-1:0] acc_q;
  logic [ID_WIDTH:0]     cnt_q;
  logic                  id_ready_q;
  logic                  mask_valid_q;

  logic [MASK_WIDTH-1:0] id_onehot;
  logic                  new_bit;

  // IDs at or beyond MASK_WIDTH decode to all-zero, so they are accepted but add no lane.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      id_onehot[i] = (id == ID_WIDTH'(i));
    end
  end

  assign new_bit = |(id_onehot & ~acc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      id_ready_q   <= 1'b1;
      mask_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (id_valid) begin
            acc_q <= acc_q | id_onehot;
            if (new_bit) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (id_last) begin
              state_q      <= HOLD;
              id_ready_q   <= 1'b0;
              mask_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (mask_ready) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            cnt_q        <= '0;
            id_ready_q   <= 1'b1;
            mask_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ACCUM;
          id_ready_q   <= 1'b1;
          mask_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign id_ready   = id_ready_q;
  assign mask_valid = mask_valid_q;
  assign mask       = acc_q;
  assign mask_count = cnt_q;

endmodule

// File: tb/tb_thread_mask_decoder.sv
// Scoreboard bench for thread_mask_decoder: expected masks are queued by the
// stimulus and popped by monitors when each DUT raises mask_valid.
module tb_thread_mask_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        id_valid, id_last, mask_ready;
  logic [4:0]  id;
  logic        id_ready, mask_valid;
  logic [31:0] mask;
  logic [5:0]  mask_count;

  logic        id_valid2, id_last2, mask_ready2;
  logic [4:0]  id2;
  logic        id_ready2, mask_valid2;
  logic [19:0] mask2;
  logic [5:0]  mask_count2;

  thread_mask_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id(id), .id_last(id_last),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask(mask), .mask_count(mask_count)
  );

  thread_mask_decoder #(.MASK_WIDTH(20)) dut20 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid2), .id_ready(id_ready2), .id(id2), .id_last(id_last2),
    .mask_valid(mask_valid2), .mask_ready(mask_ready2),
    .mask(mask2), .mask_count(mask_count2)
  );

  typedef struct packed {
    logic [31:0] m;
    logic [5:0]  c;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp2_q[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t mk(input logic [31:0] m, input logic [5:0] c);
    exp_t e;
    e.m = m;
    e.c = c;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  // monitor for the 32-lane instance: compare on the first HOLD cycle, then check stability
  exp_t cur;
  logic held = 1'b0;
  always @(negedge clk) begin
    if (mask_valid) begin
      if (!held) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mask: actual=0x%0h required=none", mask);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
          check("mask", {32'd0, mask}, {32'd0, cur.m});
          check("mask_count", {58'd0, mask_count}, {58'd0, cur.c});
        end
        held = 1'b1;
      end else begin
        check("mask_stable", {32'd0, mask}, {32'd0, cur.m});
        check("count_stable", {58'd0, mask_count}, {58'd0, cur.c});
      end
    end else begin
      held = 1'b0;
    end
  end

  exp_t cur2;
  logic held2 = 1'b0;
  always @(negedge clk) begin
    if (mask_valid2 && !held2) begin
      if (exp2_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_mask20: actual=0x%0h required=none", mask2);
      end else begin
        cur2 = exp2_q.pop_front();
        check("mask20", {44'd0, mask2}, {32'd0, cur2.m});
        check("mask_count20", {58'd0, mask_count2}, {58'd0, cur2.c});
      end
    end
    held2 = mask_valid2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] i, input logic last);
    id_valid = 1'b1;
    id       = i;
    id_last  = last;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id = '0; id_last = 1'b0; mask_ready = 1'b0;
    id_valid2 = 1'b0; id2 = '0; id_last2 = 1'b0; mask_ready2 = 1'b0;

    #12;
    check("rst_mask", {32'd0, mask}, 64'd0);
    check("rst_count", {58'd0, mask_count}, 64'd0);
    check("rst_mask_valid", {63'd0, mask_valid}, 64'd0);
    check("rst_id_ready", {63'd0, id_ready}, 64'd1);
    rst_n = 1'b1;
    mask_ready = 1'b1;

    // 0,5,31(last): 4-cycle period, valid for one cycle, no bypass in handshake cycle
    exp_q.push_back(mk(32'h8000_0021, 6'd3));
    send(5'd0, 1'b0);
    check("partial_mask", {32'd0, mask}, 64'h1);
    check("partial_valid", {63'd0, mask_valid}, 64'd0);
    send(5'd5, 1'b0);
    send(5'd31, 1'b1);
    check("hold_valid", {63'd0, mask_valid}, 64'd1);
    check("hold_id_ready", {63'd0, id_ready}, 64'd0);
    id_valid = 1'b1; id = 5'd9; id_last = 1'b0;
    step();
    id_valid = 1'b0;
    check("post_hs_valid", {63'd0, mask_valid}, 64'd0);
    check("post_hs_id_ready", {63'd0, id_ready}, 64'd1);
    check("post_hs_mask", {32'd0, mask}, 64'd0);
    check("post_hs_count", {58'd0, mask_count}, 64'd0);

    // duplicate IDs
    exp_q.push_back(mk(32'h0000_0008, 6'd1));
    send(5'd3, 1'b0);
    check("dup_count1", {58'd0, mask_count}, 64'd1);
    send(5'd3, 1'b0);
    check("dup_count2", {58'd0, mask_count}, 64'd1);
    check("dup_mask2", {32'd0, mask}, 64'h8);
    send(5'd3, 1'b1);
    id_valid = 1'b0;
    step();

    // back-pressure for 5 cycles with ignored id pulses
    mask_ready = 1'b0;
    exp_q.push_back(mk(32'h0000_0006, 6'd2));
    send(5'd1, 1'b0);
    send(5'd2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      id_valid = 1'b1; id = 5'(10 + k); id_last = 1'b1;
      check("bp_id_ready", {63'd0, id_ready}, 64'd0);
      check("bp_mask_valid", {63'd0, mask_valid}, 64'd1);
      step();
    end
    check("bp_mask_end", {32'd0, mask}, 64'h6);
    id_valid = 1'b0; id_last = 1'b0;
    mask_ready = 1'b1;
    step();
    check("bp_release_valid", {63'd0, mask_valid}, 64'd0);
    check("bp_release_ready", {63'd0, id_ready}, 64'd1);
    check("bp_release_mask", {32'd0, mask}, 64'd0);

    // all 32 lanes; i*7+3 mod 32 visits every ID once
    exp_q.push_back(mk(32'hFFFF_FFFF, 6'd32));
    for (int i = 0; i < 32; i++) begin
      send(5'((i * 7 + 3) % 32), (i == 31));
      if (i == 30) begin
        check("full_count31", {58'd0, mask_count}, 64'd31);
        check("full_valid31", {63'd0, mask_valid}, 64'd0);
      end
    end
    id_valid = 1'b0; id_last = 1'b0;
    step();

    // asynchronous reset mid-group discards it
    send(5'd4, 1'b0);
    send(5'd9, 1'b0);
    id_valid = 1'b0;
    check("pre_rst_mask", {32'd0, mask}, 64'h210);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mask", {32'd0, mask}, 64'd0);
    check("async_rst_count", {58'd0, mask_count}, 64'd0);
    check("async_rst_valid", {63'd0, mask_valid}, 64'd0);
    check("async_rst_ready", {63'd0, id_ready}, 64'd1);
    #1 rst_n = 1'b1;
    exp_q.push_back(mk(32'h0000_0080, 6'd1));
    send(5'd7, 1'b1);
    id_valid = 1'b0; id_last = 1'b0;
    check("after_rst_valid", {63'd0, mask_valid}, 64'd1);
    step();

    // 20-lane instance: ID 25 is out of range and sets nothing
    exp2_q.push_back(mk(32'h0008_0000, 6'd1));
    id_valid2 = 1'b1; id2 = 5'd19; id_last2 = 1'b0;
    step();
    check("w20_mask19", {44'd0, mask2}, 64'h80000);
    id2 = 5'd25; id_last2 = 1'b1;
    step();
    id_valid2 = 1'b0; id_last2 = 1'b0;
    check("w20_valid", {63'd0, mask_valid2}, 64'd1);
    check("w20_count", {58'd0, mask_count2}, 64'd1);
    mask_ready2 = 1'b1;
    step();
    check("w20_release", {63'd0, mask_valid2}, 64'd0);
    step();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("queue20_drained", 64'(exp2_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
